// File: rtl/fetch_queue_if.sv
// ---------------------------------------------------------------------------
// fetch_queue_if
//   Bundles the instruction-memory, redirect and consumer signals of the fetch
//   queue unit into one interface.
//
//   Parameters
//     XLEN   : PC / instruction width (32 or 64)
//     DEPTH  : fetch queue entries (power of two, >= 2)
//
//   Signals
//     imem_req        unit -> mem  : read request this cycle
//     imem_addr       unit -> mem  : read address
//     imem_rdata      mem  -> unit : read data, one cycle after the request
//     redirect_valid  ctl  -> unit : single-cycle redirect pulse
//     redirect_mode   ctl  -> unit : 0 absolute, 1 PC-relative
//     redirect_base   ctl  -> unit : absolute target or relative base
//     redirect_offset ctl  -> unit : signed offset (relative mode only)
//     inst_valid      unit -> cons : queue head valid
//     inst_ready      cons -> unit : consumer accepts head
//     inst_data       unit -> cons : head instruction word
//     inst_pc         unit -> cons : head instruction address
//     occupancy       unit -> cons : queue entry count
//     misalign_err    unit -> ctl  : pulse on misaligned redirect target
//
//   Modports
//     master : the fetch queue unit
//     slave  : memory / controller / consumer environment
// ---------------------------------------------------------------------------
interface fetch_queue_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
);

  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;

  logic             redirect_valid;
  logic             redirect_mode;
  logic [XLEN-1:0]  redirect_base;
  logic [XLEN-1:0]  redirect_offset;

  logic             inst_valid;
  logic             inst_ready;
  logic [XLEN-1:0]  inst_data;
  logic [XLEN-1:0]  inst_pc;

  logic [OCC_W-1:0] occupancy;
  logic             misalign_err;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_mode,
    input  redirect_base,
    input  redirect_offset,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    output occupancy,
    output misalign_err
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_mode,
    output redirect_base,
    output redirect_offset,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    input  occupancy,
    input  misalign_err
  );

endinterface

// File: rtl/fetch_queue_unit.sv
// ---------------------------------------------------------------------------
// fetch_queue_unit
//   Sequential instruction fetcher feeding a small circular FIFO. Issues at
//   most one memory read per cycle, keeps at most one read in flight, and
//   never issues unless the queue has room for the response. A redirect
//   flushes the queue, drops the in-flight read and restarts fetch at a new
//   (word-aligned) target.
//
//   Parameters
//     XLEN     : PC / instruction width (32 or 64)
//     DEPTH    : queue entries (power of two, >= 2)
//     RESET_PC : fetch address after reset (word-aligned)
//
//   Ports
//     clk : clock, rising edge
//     rst : asynchronous active-low reset
//     bus : fetch_queue_if master modport (memory, redirect, consumer side)
// ---------------------------------------------------------------------------
module fetch_queue_unit #(
  parameter int unsigned    XLEN     = 32,
  parameter int unsigned    DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned      PTR_W   = $clog2(DEPTH);
  localparam int unsigned      OCC_W   = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_W = OCC_W'(DEPTH);

  // Fetch state
  logic [XLEN-1:0]  r_fetch_pc;
  logic [XLEN-1:0]  r_infl_addr;
  logic             r_inflight;
  logic             r_misalign;

  // Queue state
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_count;
  logic [XLEN-1:0]  r_q_data [DEPTH];
  logic [XLEN-1:0]  r_q_pc   [DEPTH];

  // Combinational control
  logic             w_issue;
  logic             w_enq;
  logic             w_deq;
  logic [XLEN-1:0]  w_target;
  logic [OCC_W-1:0] w_pending;

  // The in-flight read reserves a slot; a same-cycle dequeue is deliberately
  // not credited here so the issue decision depends on registered state only.
  assign w_pending = r_count + OCC_W'(r_inflight);
  assign w_issue   = !bus.redirect_valid && (w_pending < DEPTH_W);

  // Enqueue/dequeue qualifiers; redirect overrides both in the state update.
  assign w_enq = r_inflight;
  assign w_deq = (r_count != '0) && bus.inst_ready;

  assign w_target = bus.redirect_base + (bus.redirect_mode ? bus.redirect_offset : '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc  <= RESET_PC;
      r_infl_addr <= '0;
      r_inflight  <= 1'b0;
      r_misalign  <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
    end else if (bus.redirect_valid) begin
      // Flush everything; the pending response is simply never written.
      r_fetch_pc <= {w_target[XLEN-1:2], 2'b00};
      r_inflight <= 1'b0;
      r_misalign <= |w_target[1:0];
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_misalign <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_fetch_pc  <= r_fetch_pc + XLEN'(4);
        r_infl_addr <= r_fetch_pc;
      end
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + OCC_W'(1);
        2'b01:   r_count <= r_count - OCC_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Queue storage carries no reset; contents are qualified by r_count.
  always_ff @(posedge clk) begin
    if (w_enq && !bus.redirect_valid) begin
      r_q_data[r_wr_ptr] <= bus.imem_rdata;
      r_q_pc[r_wr_ptr]   <= r_infl_addr;
    end
  end

  assign bus.imem_req     = w_issue;
  assign bus.imem_addr    = r_fetch_pc;
  assign bus.inst_valid   = (r_count != '0);
  assign bus.inst_data    = r_q_data[r_rd_ptr];
  assign bus.inst_pc      = r_q_pc[r_rd_ptr];
  assign bus.occupancy    = r_count;
  assign bus.misalign_err = r_misalign;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit (XLEN=32, DEPTH=4, RESET_PC=0x100).
// Memory model returns addr ^ 0xA5A5A5A5 one cycle after each sampled address.
module tb_fetch_queue_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hA5A5_A5A5;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [31:0] mem_last_addr;
  logic        tb_infl;

  fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();

  fetch_queue_unit #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .RESET_PC(32'h0000_0100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: data for the address presented before an edge appears after it.
  always @(posedge clk) mem_last_addr <= bus.imem_addr;
  assign bus.imem_rdata = mem_last_addr ^ KEY;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A response landing while the queue is already full would overflow it.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_infl <= 1'b0;
    else      tb_infl <= bus.imem_req;
  end

  always @(negedge clk) begin
    if (rst && tb_infl) begin
      check("enq_not_full", 64'(bus.occupancy < 3'(DEPTH)), 64'd1);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_mode   = 1'b0;
    bus.redirect_base   = '0;
    bus.redirect_offset = '0;
    bus.inst_ready      = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check("rst_occ",   64'(bus.occupancy),    64'd0);
    check("rst_valid", 64'(bus.inst_valid),   64'd0);
    check("rst_mis",   64'(bus.misalign_err), 64'd0);
    tick();
    tick();
    check("rst_occ_hold", 64'(bus.occupancy), 64'd0);

    // Release: cycle 0
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    check("c0_req",   64'(bus.imem_req),  64'd1);
    check("c0_addr",  64'(bus.imem_addr), 64'h100);
    check("c0_valid", 64'(bus.inst_valid), 64'd0);
    tick();
    check("c1_valid", 64'(bus.inst_valid), 64'd0);
    check("c1_addr",  64'(bus.imem_addr),  64'h104);
    tick();
    check("c2_valid", 64'(bus.inst_valid), 64'd1);
    check("c2_pc",    64'(bus.inst_pc),    64'h100);
    check("c2_data",  64'(bus.inst_data),  64'(32'h100 ^ KEY));
    check("c2_occ",   64'(bus.occupancy),  64'd1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stream_pc",   64'(bus.inst_pc),    64'(32'h100 + 4 * i));
      check("stream_data", 64'(bus.inst_data),  64'((32'h100 + 4 * i) ^ KEY));
      check("stream_occ",  64'(bus.occupancy),  64'd1);
    end

    // Back-pressure: head 0x110 held, queue fills to DEPTH
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_pc", 64'(bus.inst_pc), 64'h110);
    end
    check("stall_occ",  64'(bus.occupancy), 64'd4);
    check("stall_req",  64'(bus.imem_req),  64'd0);
    check("stall_data", 64'(bus.inst_data), 64'(32'h110 ^ KEY));

    // Drain in order
    bus.inst_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check("drain_valid", 64'(bus.inst_valid), 64'd1);
      check("drain_pc",    64'(bus.inst_pc),    64'(32'h110 + 4 * i));
      check("drain_data",  64'(bus.inst_data),  64'((32'h110 + 4 * i) ^ KEY));
    end
    check("drain_occ", 64'(bus.occupancy), 64'd2);

    // Build 3 queued entries plus an in-flight read, then relative redirect
    bus.inst_ready = 1'b0;
    tick();
    check("pre_rd_occ",  64'(bus.occupancy), 64'd3);
    check("pre_rd_pc",   64'(bus.inst_pc),   64'h128);
    check("pre_rd_addr", 64'(bus.imem_addr), 64'h138);
    bus.redirect_valid  = 1'b1;
    bus.redirect_mode   = 1'b1;
    bus.redirect_base   = 32'h0000_0200;
    bus.redirect_offset = 32'hFFFF_FFF8;
    bus.inst_ready      = 1'b1;
    #1;
    check("rd_req_low", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("rd_occ",   64'(bus.occupancy),    64'd0);
    check("rd_valid", 64'(bus.inst_valid),   64'd0);
    check("rd_addr",  64'(bus.imem_addr),    64'h1F8);
    check("rd_req",   64'(bus.imem_req),     64'd1);
    check("rd_mis",   64'(bus.misalign_err), 64'd0);
    tick();
    check("rd_stale",  64'(bus.inst_valid), 64'd0);
    tick();
    check("rd_valid2", 64'(bus.inst_valid), 64'd1);
    check("rd_pc",     64'(bus.inst_pc),    64'h1F8);
    check("rd_data",   64'(bus.inst_data),  64'(32'h1F8 ^ KEY));
    tick();
    check("rd_pc2",    64'(bus.inst_pc),    64'h1FC);

    // Back-to-back redirects, the second misaligned
    bus.redirect_valid = 1'b1;
    bus.redirect_mode  = 1'b0;
    bus.redirect_base  = 32'h0000_0400;
    #1;
    check("b2b_req0", 64'(bus.imem_req), 64'd0);
    tick();
    bus.redirect_base = 32'h0000_0303;
    #1;
    check("b2b_req1",  64'(bus.imem_req),     64'd0);
    check("b2b_addr1", 64'(bus.imem_addr),    64'h400);
    check("b2b_mis1",  64'(bus.misalign_err), 64'd0);
    check("b2b_occ1",  64'(bus.occupancy),    64'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("mis_pulse", 64'(bus.misalign_err), 64'd1);
    check("mis_addr",  64'(bus.imem_addr),    64'h300);
    check("mis_req",   64'(bus.imem_req),     64'd1);
    tick();
    check("mis_clear", 64'(bus.misalign_err), 64'd0);
    check("mis_addr2", 64'(bus.imem_addr),    64'h304);
    tick();
    check("mis_valid", 64'(bus.inst_valid), 64'd1);
    check("mis_pc",    64'(bus.inst_pc),    64'h300);
    check("mis_data",  64'(bus.inst_data),  64'(32'h300 ^ KEY));

    // Address wrap at the top of the space
    bus.redirect_valid = 1'b1;
    bus.redirect_base  = 32'hFFFF_FFF8;
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    check("wrap_a0", 64'(bus.imem_addr), 64'hFFFF_FFF8);
    tick();
    check("wrap_a1", 64'(bus.imem_addr), 64'hFFFF_FFFC);
    tick();
    check("wrap_a2",  64'(bus.imem_addr),    64'h0);
    check("wrap_mis", 64'(bus.misalign_err), 64'd0);
    check("wrap_pc0", 64'(bus.inst_pc),      64'hFFFF_FFF8);
    tick();
    check("wrap_pc1", 64'(bus.inst_pc), 64'hFFFF_FFFC);
    tick();
    check("wrap_pc2",   64'(bus.inst_pc),   64'h0);
    check("wrap_data2", 64'(bus.inst_data), 64'(KEY));

    // Reset mid-operation with a filled queue and a read in flight
    bus.inst_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_occ", 64'(bus.occupancy), 64'd3);
    #2 rst = 1'b0;
    #1;
    check("arst_occ",   64'(bus.occupancy),    64'd0);
    check("arst_valid", 64'(bus.inst_valid),   64'd0);
    check("arst_mis",   64'(bus.misalign_err), 64'd0);
    check("arst_addr",  64'(bus.imem_addr),    64'h100);
    check("arst_req",   64'(bus.imem_req),     64'd1);
    tick();
    check("arst_hold", 64'(bus.occupancy), 64'd0);
    rst = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    check("rs_valid0", 64'(bus.inst_valid), 64'd0);
    tick();
    check("rs_valid1", 64'(bus.inst_valid), 64'd1);
    check("rs_pc",     64'(bus.inst_pc),    64'h100);
    check("rs_data",   64'(bus.inst_data),  64'(32'h100 ^ KEY));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
